// File: rtl/servo_scan_sequencer_if.sv
// Command/status bundle between the register block (master) and the scan sequencer (slave).
// Inputs are sampled on the rising PCLK edge; every sequencer output is a registered level or one-cycle strobe.
interface servo_scan_sequencer_if;
   logic        start;
   logic        abort;
   logic [15:0] cfg_x_periods;
   logic [15:0] cfg_y_periods;
   logic [7:0]  cfg_rows;
   logic [1:0]  stop_y;
   logic        x_fwd;
   logic        x_rev;
   logic        x_neutral;
   logic        x_rtz;
   logic        y_fwd;
   logic        y_rev;
   logic        y_neutral;
   logic        y_rtz;
   logic        busy;
   logic        done;
   logic        fault;
   logic [7:0]  row_idx;
   logic [1:0]  dbg_state;

   modport master (
      output start, abort, cfg_x_periods, cfg_y_periods, cfg_rows, stop_y,
      input  x_fwd, x_rev, x_neutral, x_rtz, y_fwd, y_rev, y_neutral, y_rtz,
      input  busy, done, fault, row_idx, dbg_state
   );

   modport slave (
      input  start, abort, cfg_x_periods, cfg_y_periods, cfg_rows, stop_y,
      output x_fwd, x_rev, x_neutral, x_rtz, y_fwd, y_rev, y_neutral, y_rtz,
      output busy, done, fault, row_idx, dbg_state
   );
endinterface

// File: rtl/servo_scan_sequencer.sv
// Serpentine raster sequencer for the x/y tracking servos, with its own PWM-period timebase.
// Optional kill-switch monitoring on stop_y is enabled by defining SERVO_SEQ_KILL_EN.
module servo_scan_sequencer #(
   parameter int unsigned PERIOD_CYCLES = 2000000,
   parameter int unsigned HOME_MARGIN   = 2
) (
   input logic             PCLK,
   input logic             PRESET,
   servo_scan_sequencer_if.slave bus
);

   localparam int unsigned TW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [TW-1:0] PMAX = TW'(PERIOD_CYCLES - 1);

   // Strobe vector bit positions: {rtz, neutral, rev, fwd}
   localparam logic [3:0] C_FWD = 4'b0001;
   localparam logic [3:0] C_REV = 4'b0010;
   localparam logic [3:0] C_NEU = 4'b0100;
   localparam logic [3:0] C_RTZ = 4'b1000;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SWEEP_X = 2'd1,
      S_STEP_Y  = 2'd2,
      S_HOME    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] ptimer_q, ptimer_d;
   logic [24:0]   pcnt_q, pcnt_d;
   logic [15:0]   xper_q, xper_d;
   logic [15:0]   yper_q, yper_d;
   logic [7:0]    rows_q, rows_d;
   logic [7:0]    row_q, row_d;
   logic [15:0]   xpos_q, xpos_d;
   logic [23:0]   ypos_q, ypos_d;
   logic          fault_q, fault_d;
   logic          rtz_pend_q, rtz_pend_d;
   logic [3:0]    xs_q, xs_d;
   logic [3:0]    ys_q, ys_d;
   logic          done_q, done_d;

   logic          tick;
   logic          phase_end;
   logic          start_ok;
   logic [24:0]   pcnt_dec;
   logic [15:0]   x_step;
   logic [7:0]    next_row;
   logic [3:0]    next_dir;

   function automatic logic [24:0] home_cnt(input logic [15:0] xp, input logic [23:0] yp);
      logic [23:0] m;
      m = ({8'd0, xp} > yp) ? {8'd0, xp} : yp;
      return {1'b0, m} + 25'(HOME_MARGIN);
   endfunction

   assign tick      = (ptimer_q == PMAX);
   assign phase_end = tick && (pcnt_q <= 25'd1);
   assign pcnt_dec  = (pcnt_q == 25'd0) ? 25'd0 : pcnt_q - 25'd1;
   assign start_ok  = bus.start && !bus.abort &&
                      (bus.cfg_rows != 8'd0) && (bus.cfg_x_periods != 16'd0);
   // Even rows sweep forward, odd rows sweep back, so x_pos never underflows.
   assign x_step    = row_q[0] ? xpos_q - 16'd1 : xpos_q + 16'd1;
   assign next_row  = row_q + 8'd1;
   assign next_dir  = next_row[0] ? C_REV : C_FWD;

   always_comb begin
      state_d    = state_q;
      ptimer_d   = tick ? '0 : ptimer_q + TW'(1);
      pcnt_d     = pcnt_q;
      xper_d     = xper_q;
      yper_d     = yper_q;
      rows_d     = rows_q;
      row_d      = row_q;
      xpos_d     = xpos_q;
      ypos_d     = ypos_q;
      fault_d    = fault_q;
      rtz_pend_d = 1'b0;
      xs_d       = 4'b0000;
      ys_d       = 4'b0000;
      done_d     = 1'b0;

      if (state_q != S_IDLE && bus.abort) begin
         xs_d    = C_NEU;
         ys_d    = C_NEU;
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  ptimer_d = '0;
                  xper_d   = bus.cfg_x_periods;
                  yper_d   = bus.cfg_y_periods;
                  rows_d   = bus.cfg_rows;
                  row_d    = 8'd0;
                  xpos_d   = 16'd0;
                  ypos_d   = 24'd0;
                  fault_d  = 1'b0;
                  xs_d     = C_FWD;
                  pcnt_d   = {9'd0, bus.cfg_x_periods};
                  state_d  = S_SWEEP_X;
               end
            end
            S_SWEEP_X: begin
               if (tick) begin
                  xpos_d = x_step;
                  pcnt_d = pcnt_dec;
                  if (phase_end) begin
                     if (row_q == rows_q - 8'd1) begin
                        xs_d    = C_RTZ;
                        ys_d    = C_RTZ;
                        pcnt_d  = home_cnt(x_step, ypos_q);
                        state_d = S_HOME;
                     end else if (yper_q != 16'd0) begin
                        xs_d    = C_NEU;
                        ys_d    = C_FWD;
                        pcnt_d  = {9'd0, yper_q};
                        state_d = S_STEP_Y;
                     end else begin
                        row_d  = next_row;
                        xs_d   = next_dir;
                        pcnt_d = {9'd0, xper_q};
                     end
                  end
               end
            end
            S_STEP_Y: begin
`ifdef SERVO_SEQ_KILL_EN
               // Lower limit hit: stop y now, issue the rtz pair one cycle later.
               if (!bus.stop_y[0]) begin
                  fault_d    = 1'b1;
                  ys_d       = C_NEU;
                  rtz_pend_d = 1'b1;
                  pcnt_d     = home_cnt(xpos_q, ypos_q);
                  state_d    = S_HOME;
               end else
`endif
               if (tick) begin
                  ypos_d = ypos_q + 24'd1;
                  pcnt_d = pcnt_dec;
                  if (phase_end) begin
                     ys_d    = C_NEU;
                     xs_d    = next_dir;
                     row_d   = next_row;
                     pcnt_d  = {9'd0, xper_q};
                     state_d = S_SWEEP_X;
                  end
               end
            end
            S_HOME: begin
               if (rtz_pend_q) begin
                  xs_d = C_RTZ;
                  ys_d = C_RTZ;
               end
`ifdef SERVO_SEQ_KILL_EN
               else if (!bus.stop_y[1] && !fault_q) begin
                  fault_d = 1'b1;
                  ys_d    = C_NEU;
               end
`endif
               if (tick) begin
                  pcnt_d = pcnt_dec;
                  if (phase_end) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q    <= S_IDLE;
         ptimer_q   <= '0;
         pcnt_q     <= 25'd0;
         xper_q     <= 16'd0;
         yper_q     <= 16'd0;
         rows_q     <= 8'd0;
         row_q      <= 8'd0;
         xpos_q     <= 16'd0;
         ypos_q     <= 24'd0;
         fault_q    <= 1'b0;
         rtz_pend_q <= 1'b0;
         xs_q       <= 4'b0000;
         ys_q       <= 4'b0000;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptimer_q   <= ptimer_d;
         pcnt_q     <= pcnt_d;
         xper_q     <= xper_d;
         yper_q     <= yper_d;
         rows_q     <= rows_d;
         row_q      <= row_d;
         xpos_q     <= xpos_d;
         ypos_q     <= ypos_d;
         fault_q    <= fault_d;
         rtz_pend_q <= rtz_pend_d;
         xs_q       <= xs_d;
         ys_q       <= ys_d;
         done_q     <= done_d;
      end
   end

`ifndef SERVO_SEQ_KILL_EN
   logic unused_stop_y;
   assign unused_stop_y = ^bus.stop_y;
`endif

   assign bus.x_fwd     = xs_q[0];
   assign bus.x_rev     = xs_q[1];
   assign bus.x_neutral = xs_q[2];
   assign bus.x_rtz     = xs_q[3];
   assign bus.y_fwd     = ys_q[0];
   assign bus.y_rev     = ys_q[1];
   assign bus.y_neutral = ys_q[2];
   assign bus.y_rtz     = ys_q[3];
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;
   assign bus.fault     = fault_q;
   assign bus.row_idx   = row_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_servo_scan_sequencer.sv
// Directed bench for servo_scan_sequencer with a 10-cycle period and a home margin of 2.
// Strobe vector order: {y_rtz, y_neutral, y_rev, y_fwd, x_rtz, x_neutral, x_rev, x_fwd}.
module tb_servo_scan_sequencer;

   logic PCLK = 1'b0;
   logic PRESET;
   int   total = 0;
   int   bad   = 0;

   servo_scan_sequencer_if sif();

   servo_scan_sequencer #(
      .PERIOD_CYCLES(10),
      .HOME_MARGIN  (2)
   ) dut (
      .PCLK  (PCLK),
      .PRESET(PRESET),
      .bus   (sif)
   );

   always #5 PCLK = ~PCLK;

   wire [7:0] strb = {sif.y_rtz, sif.y_neutral, sif.y_rev, sif.y_fwd,
                      sif.x_rtz, sif.x_neutral, sif.x_rev, sif.x_fwd};

   typedef struct {
      int rows;
      int xp;
      int yp;
      int done_cyc;
      int exp_row;
      int kill_cyc;
      int exp_fault;
   } scan_t;

   typedef struct {
      int         scan;
      int         cyc;
      logic [7:0] strb;
   } ev_t;

   scan_t scans[5];
   ev_t   evs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_ev(input int s, input int c, input logic [7:0] v);
      ev_t e;
      e.scan = s;
      e.cyc  = c;
      e.strb = v;
      evs.push_back(e);
   endtask

   task automatic pulse_start(input int rows, input int xp, input int yp, input logic ab);
      @(negedge PCLK);
      sif.cfg_rows      = 8'(rows);
      sif.cfg_x_periods = 16'(xp);
      sif.cfg_y_periods = 16'(yp);
      sif.start         = 1'b1;
      sif.abort         = ab;
      @(negedge PCLK);
      sif.start = 1'b0;
      sif.abort = 1'b0;
   endtask

   // Cycle c is sampled on the falling edge after the c-th rising edge following start.
   task automatic run_scan(input int s);
      logic [7:0] e;
      pulse_start(scans[s].rows, scans[s].xp, scans[s].yp, 1'b0);
      for (int c = 1; c <= scans[s].done_cyc; c++) begin
         e = 8'h00;
         foreach (evs[i]) if (evs[i].scan == s && evs[i].cyc == c) e = evs[i].strb;
         check($sformatf("scan%0d strb c%0d", s, c), strb, e);
         check($sformatf("scan%0d busy c%0d", s, c), sif.busy, (c < scans[s].done_cyc));
         check($sformatf("scan%0d done c%0d", s, c), sif.done, (c == scans[s].done_cyc));
         sif.stop_y = (c == scans[s].kill_cyc) ? 2'b10 : 2'b11;
         @(negedge PCLK);
      end
      check($sformatf("scan%0d done after", s), sif.done, 1'b0);
      check($sformatf("scan%0d strb after", s), strb, 8'h00);
      check($sformatf("scan%0d row_idx", s), sif.row_idx, scans[s].exp_row);
      check($sformatf("scan%0d fault", s), sif.fault, scans[s].exp_fault);
   endtask

   task automatic idle_quiet(input string name, input int n);
      int viol;
      viol = 0;
      for (int c = 0; c < n; c++) begin
         if (strb != 8'h00 || sif.busy !== 1'b0 || sif.done !== 1'b0) viol++;
         @(negedge PCLK);
      end
      check(name, viol, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      scans[0] = '{2, 3, 2, 121, 1, 0, 0};
      scans[1] = '{3, 1, 0, 61, 2, 0, 0};
      scans[2] = '{1, 2, 7, 61, 0, 0, 0};
      scans[3] = '{3, 2, 1, 121, 2, 0, 0};
      scans[4] = '{4, 2, 5, 81, 0, 40, 1};
      add_ev(0, 1, 8'h01); add_ev(0, 31, 8'h14); add_ev(0, 51, 8'h42); add_ev(0, 81, 8'h88);
      add_ev(1, 1, 8'h01); add_ev(1, 11, 8'h02); add_ev(1, 21, 8'h01); add_ev(1, 31, 8'h88);
      add_ev(2, 1, 8'h01); add_ev(2, 21, 8'h88);
      add_ev(3, 1, 8'h01); add_ev(3, 21, 8'h14); add_ev(3, 31, 8'h42);
      add_ev(3, 51, 8'h14); add_ev(3, 61, 8'h41); add_ev(3, 81, 8'h88);
      add_ev(4, 1, 8'h01); add_ev(4, 21, 8'h14); add_ev(4, 41, 8'h40); add_ev(4, 42, 8'h88);

      PRESET            = 1'b1;
      sif.start         = 1'b0;
      sif.abort         = 1'b0;
      sif.cfg_rows      = 8'd0;
      sif.cfg_x_periods = 16'd0;
      sif.cfg_y_periods = 16'd0;
      sif.stop_y        = 2'b11;
      repeat (3) @(negedge PCLK);
      check("reset strb", strb, 8'h00);
      check("reset busy", sif.busy, 1'b0);
      check("reset done", sif.done, 1'b0);
      check("reset fault", sif.fault, 1'b0);
      check("reset row_idx", sif.row_idx, 8'd0);
      check("reset state", sif.dbg_state, 2'd0);
      PRESET = 1'b0;
      repeat (2) @(negedge PCLK);

      for (int s = 0; s < 4; s++) begin
         run_scan(s);
         repeat (3) @(negedge PCLK);
      end
`ifdef SERVO_SEQ_KILL_EN
      run_scan(4);
      repeat (3) @(negedge PCLK);
`endif

      pulse_start(0, 5, 1, 1'b0);
      idle_quiet("zero rows ignored", 15);
      pulse_start(2, 0, 1, 1'b0);
      idle_quiet("zero x ignored", 15);
      pulse_start(2, 3, 2, 1'b1);
      idle_quiet("start with abort ignored", 15);

      // Abort during the first y step (STEP_Y spans cycles 31..51).
      pulse_start(2, 3, 2, 1'b0);
      repeat (34) @(negedge PCLK);
      check("abort pre state", sif.dbg_state, 2'd2);
      sif.abort = 1'b1;
      @(negedge PCLK);
      sif.abort = 1'b0;
      check("abort strb", strb, 8'h44);
      check("abort busy", sif.busy, 1'b0);
      check("abort done", sif.done, 1'b0);
      @(negedge PCLK);
      idle_quiet("abort no done", 40);
      pulse_start(1, 1, 0, 1'b0);
      check("restart strb", strb, 8'h01);
      check("restart busy", sif.busy, 1'b1);
      check("restart fault", sif.fault, 1'b0);
      repeat (45) @(negedge PCLK);
      check("restart finished", sif.busy, 1'b0);

      // Reset while row 1 is being swept, right when a strobe pair is showing.
      pulse_start(2, 3, 2, 1'b0);
      repeat (50) @(negedge PCLK);
      check("mid strb", strb, 8'h42);
      check("mid row_idx", sif.row_idx, 8'd1);
      #2 PRESET = 1'b1;
      #1;
      check("async rst strb", strb, 8'h00);
      check("async rst busy", sif.busy, 1'b0);
      check("async rst row_idx", sif.row_idx, 8'd0);
      check("async rst done", sif.done, 1'b0);
      @(negedge PCLK);
      PRESET = 1'b0;
      repeat (4) @(negedge PCLK);
      run_scan(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
